// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit and the ALU function decoder.
// The ADDI_EX/ADDI_WB states exist only when MC_CTRL_ADDI_EN is defined.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EX     = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BEQ      = 4'd8,
    ST_JUMP     = 4'd9
`ifdef MC_CTRL_ADDI_EN
    ,
    ST_ADDI_EX  = 4'd10,
    ST_ADDI_WB  = 4'd11
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_out_dec.sv
// Moore output decode: state (plus mem_ready in the handshake states) to the datapath control vector.
// Unused encodings decode to all zeros.
module mc_ctrl_out_dec
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state,
  input  logic               mem_ready,
  output ctrl_t              ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_R_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      ST_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ST_ADDI_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main control FSM: state register, next-state logic and reset gating of write strobes.
// Optional addi support is enabled by defining MC_CTRL_ADDI_EN.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op
);

  logic [STATE_W-1:0] state, state_nxt;
  logic               illegal;
  ctrl_t              ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_FETCH;
    illegal   = 1'b0;
    case (state)
      ST_FETCH:    state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
          OP_RTYPE:     state_nxt = ST_R_EX;
          OP_BEQ:       state_nxt = ST_BEQ;
          OP_J:         state_nxt = ST_JUMP;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_nxt = ST_ADDI_EX;
`endif
          default: begin
            state_nxt = ST_FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: state_nxt = (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   state_nxt = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:   state_nxt = ST_FETCH;
      ST_MEM_WR:   state_nxt = mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_R_EX:     state_nxt = ST_R_WB;
      ST_R_WB:     state_nxt = ST_FETCH;
      ST_BEQ:      state_nxt = ST_FETCH;
      ST_JUMP:     state_nxt = ST_FETCH;
`ifdef MC_CTRL_ADDI_EN
      ST_ADDI_EX:  state_nxt = ST_ADDI_WB;
      ST_ADDI_WB:  state_nxt = ST_FETCH;
`endif
      default:     state_nxt = ST_FETCH;
    endcase
  end

  mc_ctrl_out_dec #(
    .STATE_W (STATE_W)
  ) u_out_dec (
    .state     (state),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  // Write strobes are held low while rst_n is asserted; the rest already show FETCH values.
  assign pc_write      = ctrl.pc_write      & rst_n;
  assign pc_write_cond = ctrl.pc_write_cond & rst_n;
  assign mem_write     = ctrl.mem_write     & rst_n;
  assign ir_write      = ctrl.ir_write      & rst_n;
  assign reg_write     = ctrl.reg_write     & rst_n;
  assign instr_done    = ctrl.instr_done    & rst_n;
  assign illegal_op    = illegal            & rst_n;

  assign iord       = ctrl.iord;
  assign mem_read   = ctrl.mem_read;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_source  = ctrl.pc_source;

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle main control unit for the MIPS datapath. It decodes the 6-bit instruction opcode over a sequence of states and drives every datapath enable and mux select. It is the producer end of the `alu_op` interface: it generates the 2-bit `alu_op` that the ALU function decoder turns into the 4-bit ALU control. Memory states stall on a `mem_ready` handshake.

## Interface
Parameters:
- `STATE_W`, default 4: width of the state register.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `op` input 6: opcode, `IR[31:26]`. Sampled in DECODE.
- `mem_ready` input 1: memory has completed the current read or write.
- `pc_write` output 1: unconditional PC write enable.
- `pc_write_cond` output 1: PC write qualified by ALU zero.
- `iord` output 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `ir_write` output 1: instruction register load.
- `mem_to_reg` output 1: write-back data select; 1 = MDR.
- `reg_dst` output 1: destination register select; 1 = rd, 0 = rt.
- `reg_write` output 1: register file write enable.
- `alu_src_a` output 1: ALU A select; 0 = PC, 1 = A.
- `alu_src_b` output 2: ALU B select; 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate.
- `alu_op` output 2: 00 = add, 01 = subtract, 10 = decode from funct.
- `pc_source` output 2: PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_done` output 1: one-cycle pulse in the final cycle of each instruction.
- `illegal_op` output 1: one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- Moore FSM. All outputs decode combinationally from the state, plus `mem_ready` where noted. Any output not listed for a state is 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010. With the configuration macro, also addi 001000.

States and their outputs:
- FETCH (0): `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00, `ir_write`=`pc_write`=`mem_ready`. Stays in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE (1): `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Next state by opcode:
  - lw or sw → MEM_ADDR.
  - R-type → R_EX.
  - beq → BEQ.
  - j → JUMP.
  - addi → ADDI_EX.
  - Any other opcode → FETCH, with `illegal_op`=1.
- MEM_ADDR (2): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: lw → MEM_RD, sw → MEM_WR.
- MEM_RD (3): `mem_read`=1, `iord`=1. Holds until `mem_ready`=1, then goes to MEM_WB.
- MEM_WB (4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Next: FETCH.
- MEM_WR (5): `mem_write`=1, `iord`=1. Holds until `mem_ready`=1, then goes to FETCH.
- R_EX (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Next: R_WB.
- R_WB (7): `reg_dst`=1, `reg_write`=1. Next: FETCH.
- BEQ (8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Next: FETCH.
- JUMP (9): `pc_write`=1, `pc_source`=10. Next: FETCH.
- ADDI_EX (10): `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Next: ADDI_WB.
- ADDI_WB (11): `reg_write`=1, `reg_dst`=0. Next: FETCH.
- Unused state encodings go to FETCH on the next clock. All outputs are 0 in those states.

`instr_done` and `illegal_op`:
- `instr_done`=1 in MEM_WB, R_WB, BEQ, JUMP and ADDI_WB.
- `instr_done`=1 in MEM_WR only in the cycle where `mem_ready`=1.
- `illegal_op` and `instr_done` are never asserted together.

## Timing
- Cycle counts with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle. Outputs hold stable while waiting.
- Reset: while `rst_n`=0, state=FETCH.
- Reset values of the write strobes: `pc_write`, `ir_write`, `pc_write_cond`, `reg_write`, `mem_write`, `instr_done` and `illegal_op` are forced to 0 by `rst_n`.
- Reset values of the other outputs: they take their FETCH values: `mem_read`=1, `alu_src_b`=01, everything else 0.
- An asynchronous reset in any state, including mid-wait, aborts the instruction. The first clock after release evaluates FETCH.
- A `mem_ready` pulse outside FETCH, MEM_RD and MEM_WR is ignored.

## Configuration
- Macro `MC_CTRL_ADDI_EN`.
- Defined: opcode 001000 is supported and the ADDI_EX and ADDI_WB states exist.
- Undefined: those states are not compiled. Opcode 001000 is illegal: DECODE → FETCH with `illegal_op`=1.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state encoding constants;
  - the opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`);
  - the `alu_op` constants (`ALUOP_ADD`=00, `ALUOP_SUB`=01, `ALUOP_FUNCT`=10), which the ALU function decoder also uses.
- One sub-module, `mc_ctrl_out_dec`: purely combinational map from state and `mem_ready` to the output vector. The state register and next-state logic stay in `mc_ctrl_fsm`.

## Test plan
- Reset: assert `rst_n`=0 mid-MEM_RD → all strobes 0, `mem_read`=1, `alu_src_b`=01. Release with `mem_ready`=1 → DECODE on the next edge.
- lw with `mem_ready`=1 → states 0,1,2,3,4. `instr_done` in cycle 5 only. `alu_op` sequence 00,00,00,-,-.
- sw with `mem_ready` low for 3 cycles in MEM_WR → `mem_write`=1 and `iord`=1 for 4 cycles. `instr_done` coincides with `mem_ready`=1. Total 7 cycles.
- R-type then beq → `alu_op`=10 in R_EX, `reg_dst`=1 in R_WB. Then `alu_op`=01 with `pc_write_cond`=1 and `pc_source`=01 in BEQ. Total 7 cycles.
- j → `pc_write`=1 and `pc_source`=10 in cycle 3, then back to FETCH.
- op=001000: with `MC_CTRL_ADDI_EN` → 4-cycle addi with `reg_write`=1 and `reg_dst`=0. Without it → `illegal_op` pulses in cycle 2, then FETCH.
